// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared encodings, control word and condition helper for the control path
package ctrl_pkg;

  typedef enum logic [1:0] {
    OP_DP  = 2'b00,
    OP_MEM = 2'b01,
    OP_BR  = 2'b10,
    OP_NOP = 2'b11
  } op_t;

  localparam logic [3:0] ALU_ADD = 4'b0100;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_BX  = 4'b1101;

  localparam logic [5:0] FUNCT_BX = 6'b010010;

  localparam logic [3:0] COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'ha, COND_LT = 4'hb;
  localparam logic [3:0] COND_GT = 4'hc, COND_LE = 4'hd, COND_AL = 4'he, COND_NV = 4'hf;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [1:0] SH_ROR = 2'b11;

  typedef struct packed {
    logic [3:0] cond;
    logic       reg_write;
    logic       mem_write;
    logic       mem_to_reg;
    logic       pc_src;
    logic       branch;
    logic       bl;
    logic       alu_src;
    logic [1:0] flag_write;
    logic [3:0] alu_control;
    logic [1:0] shift_control;
    logic [4:0] shamt;
  } ctrl_word_t;

  localparam ctrl_word_t CTRL_BUBBLE = '0;

  function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    n = nzcv[FLAG_N];
    z = nzcv[FLAG_Z];
    c = nzcv[FLAG_C];
    v = nzcv[FLAG_V];
    case (cond)
      COND_EQ: cond_holds = z;
      COND_NE: cond_holds = ~z;
      COND_CS: cond_holds = c;
      COND_CC: cond_holds = ~c;
      COND_MI: cond_holds = n;
      COND_PL: cond_holds = ~n;
      COND_VS: cond_holds = v;
      COND_VC: cond_holds = ~v;
      COND_HI: cond_holds = c & ~z;
      COND_LS: cond_holds = ~c | z;
      COND_GE: cond_holds = (n == v);
      COND_LT: cond_holds = (n != v);
      COND_GT: cond_holds = ~z & (n == v);
      COND_LE: cond_holds = z | (n != v);
      COND_AL: cond_holds = 1'b1;
      default: cond_holds = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cond_check.sv
// rtl/cond_check.sv - Execute-stage condition evaluation and the NZCV flag register
module cond_check
  import ctrl_pkg::*;
#(
  parameter bit         COND_EN     = 1'b1,
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] cond,
  input  logic [1:0] flag_write,
  input  logic       hold,
  input  logic [3:0] alu_flags,
  output logic       cond_ex,
  output logic [3:0] flags_q
);

  assign cond_ex = COND_EN ? cond_holds(cond, flags_q) : 1'b1;

  // A stalled instruction re-executes next cycle, so its flags must not land yet.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flags_q <= RESET_FLAGS;
    end else if (!hold && cond_ex) begin
      if (flag_write[0]) begin
        flags_q[FLAG_N] <= alu_flags[FLAG_N];
        flags_q[FLAG_Z] <= alu_flags[FLAG_Z];
      end
      if (flag_write[1]) begin
        flags_q[FLAG_C] <= alu_flags[FLAG_C];
        flags_q[FLAG_V] <= alu_flags[FLAG_V];
      end
    end
  end

endmodule

// File: rtl/pipe_ctrl_path.sv
// rtl/pipe_ctrl_path.sv - ARM-subset control path: decode plus D/E, E/M, M/W control registers
module pipe_ctrl_path
  import ctrl_pkg::*;
#(
  parameter int         ALU_CTRL_W  = 4,
  parameter bit         COND_EN     = 1'b1,
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           instr_d,
  input  logic                  stall_e,
  input  logic                  flush_e,
  input  logic [3:0]            alu_flags_e,
  output logic [1:0]            imm_src_d,
  output logic [2:0]            reg_src_d,
  output logic [ALU_CTRL_W-1:0] alu_control_e,
  output logic                  alu_src_e,
  output logic                  cond_ex_e,
  output logic                  branch_taken_e,
  output logic [1:0]            shift_control_e,
  output logic [4:0]            shamt_e,
  output logic                  reg_write_m,
  output logic                  mem_write_m,
  output logic                  mem_to_reg_m,
  output logic                  pc_src_m,
  output logic                  reg_write_w,
  output logic                  mem_to_reg_w,
  output logic                  pc_src_w,
  output logic                  bl_w,
  output logic [3:0]            flags_q
);

  logic [1:0]  op_bits;
  logic [5:0]  funct;
  logic [3:0]  rd;
  logic [11:0] src2;
  logic        dp_write;
  logic        nz_only;

  assign op_bits  = instr_d[27:26];
  assign funct    = instr_d[25:20];
  assign rd       = instr_d[15:12];
  assign src2     = instr_d[11:0];
  assign dp_write = (funct[4:3] != 2'b10);
  // Logical ops leave C,V alone; arithmetic ones update all four flags.
  assign nz_only  = (funct[4:2] == 3'b000) || (funct[4:2] == 3'b100) || (funct[4:3] == 2'b11);

  ctrl_word_t ctrl_d, ctrl_e, de_q, em_q, mw_q;
  logic       cond_ex;

  always_comb begin
    ctrl_d      = CTRL_BUBBLE;
    imm_src_d   = 2'b00;
    reg_src_d   = 3'b000;
    ctrl_d.cond = instr_d[31:28];
    case (op_t'(op_bits))
      OP_DP: begin
        if (funct == FUNCT_BX && rd == 4'hf) begin
          ctrl_d.branch      = 1'b1;
          ctrl_d.pc_src      = 1'b1;
          ctrl_d.alu_control = ALU_BX;
        end else begin
          ctrl_d.reg_write = dp_write;
          ctrl_d.alu_src   = funct[5];
          ctrl_d.pc_src    = (rd == 4'hf) && dp_write;
          if (dp_write)                ctrl_d.alu_control = funct[4:1];
          else if (funct[2:1] == 2'b11) ctrl_d.alu_control = ALU_ADD;
          else                          ctrl_d.alu_control = {1'b0, funct[3:1]};
          if (funct[0]) ctrl_d.flag_write = nz_only ? 2'b01 : 2'b11;
          if (funct[5]) begin
            ctrl_d.shift_control = SH_ROR;
            ctrl_d.shamt         = {src2[11:8], 1'b0};
          end else begin
            ctrl_d.shift_control = src2[6:5];
            ctrl_d.shamt         = src2[11:7];
          end
        end
      end
      OP_MEM: begin
        ctrl_d.reg_write   = funct[0];
        ctrl_d.mem_to_reg  = funct[0];
        ctrl_d.mem_write   = ~funct[0];
        ctrl_d.alu_src     = ~funct[5];
        ctrl_d.alu_control = funct[3] ? ALU_ADD : ALU_SUB;
        reg_src_d          = 3'b010;
        imm_src_d          = 2'b01;
      end
      OP_BR: begin
        ctrl_d.pc_src      = 1'b1;
        ctrl_d.branch      = 1'b1;
        ctrl_d.reg_write   = funct[4];
        ctrl_d.bl          = funct[4];
        ctrl_d.alu_src     = 1'b1;
        ctrl_d.alu_control = ALU_ADD;
        reg_src_d          = {funct[4], 2'b01};
        imm_src_d          = 2'b10;
      end
      default: ;
    endcase
  end

  cond_check #(
    .COND_EN     (COND_EN),
    .RESET_FLAGS (RESET_FLAGS)
  ) u_cond_check (
    .clk        (clk),
    .rst_n      (rst_n),
    .cond       (de_q.cond),
    .flag_write (de_q.flag_write),
    .hold       (stall_e),
    .alu_flags  (alu_flags_e),
    .cond_ex    (cond_ex),
    .flags_q    (flags_q)
  );

  // Squashed instructions keep flowing but lose every architectural side effect.
  always_comb begin
    ctrl_e            = de_q;
    ctrl_e.reg_write  = de_q.reg_write & cond_ex;
    ctrl_e.mem_write  = de_q.mem_write & cond_ex;
    ctrl_e.pc_src     = de_q.pc_src & cond_ex;
    ctrl_e.branch     = de_q.branch & cond_ex;
    ctrl_e.flag_write = de_q.flag_write & {2{cond_ex}};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      de_q <= CTRL_BUBBLE;
      em_q <= CTRL_BUBBLE;
      mw_q <= CTRL_BUBBLE;
    end else begin
      if (flush_e)       de_q <= CTRL_BUBBLE;
      else if (!stall_e) de_q <= ctrl_d;
      em_q <= stall_e ? CTRL_BUBBLE : ctrl_e;
      mw_q <= em_q;
    end
  end

  assign alu_control_e   = ALU_CTRL_W'(de_q.alu_control);
  assign alu_src_e       = de_q.alu_src;
  assign shift_control_e = de_q.shift_control;
  assign shamt_e         = de_q.shamt;
  assign cond_ex_e       = cond_ex;
  assign branch_taken_e  = de_q.branch & cond_ex;

  assign reg_write_m  = em_q.reg_write;
  assign mem_write_m  = em_q.mem_write;
  assign mem_to_reg_m = em_q.mem_to_reg;
  assign pc_src_m     = em_q.pc_src;

  assign reg_write_w  = mw_q.reg_write;
  assign mem_to_reg_w = mw_q.mem_to_reg;
  assign pc_src_w     = mw_q.pc_src;
  assign bl_w         = mw_q.bl;

  logic unused_bits;
  assign unused_bits = ^{instr_d[19:16], instr_d[4:0], em_q, mw_q};

endmodule
